// File: rtl/soc_mgmt_rst_seq_ctrl.sv
// Warm-reset sequencer: drives per-stage reset requests deepest stage first and
// releases them shallowest first, gating each step on the generator ack with an optional timeout.
module soc_mgmt_rst_seq_ctrl #(
    parameter int NUM_STAGES = 3,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_STAGES-1:0] i_req,
    input  logic [NUM_STAGES-1:0] i_rst_ack_n,
    input  logic [CNT_W-1:0]      i_hold_cycles,
    input  logic [CNT_W-1:0]      i_timeout_cycles,
    input  logic                  i_err_clr,
    output logic [NUM_STAGES-1:0] o_rst_req_n,
    output logic                  o_busy,
    output logic [1:0]            o_active_stage,
    output logic                  o_done,
    output logic                  o_err,
    output logic [1:0]            o_err_stage,
    output logic [NUM_STAGES-1:0] o_pending
);

    localparam logic [1:0] LAST_STAGE = 2'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic logic [1:0] lowest_idx(input logic [NUM_STAGES-1:0] vec);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 2'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Stage k and every stage above it share one sequence.
    function automatic logic [NUM_STAGES-1:0] scope_mask(input logic [1:0] stage);
        logic [NUM_STAGES-1:0] mask;
        for (int i = 0; i < NUM_STAGES; i++) begin
            mask[i] = (i >= int'(stage));
        end
        return mask;
    endfunction

    state_t                state_r, state_nx_s;
    logic [1:0]            k_r, k_nx_s;
    logic [1:0]            cur_r, cur_nx_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nx_s, cnt_inc_s, hold_len_s;
    logic [NUM_STAGES-1:0] pending_r, clr_mask_s;
    logic [NUM_STAGES-1:0] req_n_r, req_n_nx_s;
    logic                  err_r, err_nx_s;
    logic [1:0]            err_stage_r, err_stage_nx_s;
    logic                  busy_r, done_r;
    logic [1:0]            active_r;
    logic                  tmo_hit_s, tmo_evt_s;

    // Next-state, counter, request-line and error-flag logic.
    always_comb begin
        state_nx_s     = state_r;
        k_nx_s         = k_r;
        cur_nx_s       = cur_r;
        cnt_nx_s       = cnt_r;
        req_n_nx_s     = req_n_r;
        err_nx_s       = err_r;
        err_stage_nx_s = err_stage_r;
        clr_mask_s     = '0;
        tmo_evt_s      = 1'b0;
        cnt_inc_s      = cnt_r + CNT_W'(1);
        tmo_hit_s      = (i_timeout_cycles != '0) && (cnt_inc_s == i_timeout_cycles);
        hold_len_s     = (i_hold_cycles == '0) ? CNT_W'(1) : i_hold_cycles;

        case (state_r)
            ST_IDLE: begin
                if (pending_r != '0) begin
                    k_nx_s     = lowest_idx(pending_r);
                    cur_nx_s   = LAST_STAGE;
                    cnt_nx_s   = '0;
                    state_nx_s = ST_ASSERT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ASSERT: begin
                req_n_nx_s[cur_r] = 1'b0;
                if (!i_rst_ack_n[cur_r] || tmo_hit_s) begin
                    cnt_nx_s  = '0;
                    tmo_evt_s = i_rst_ack_n[cur_r];
                    if (cur_r == k_r) begin
                        state_nx_s = ST_HOLD;
                    end else begin
                        cur_nx_s = cur_r - 2'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_inc_s;
                end
            end
            ST_HOLD: begin
                if (cnt_inc_s >= hold_len_s) begin
                    cnt_nx_s   = '0;
                    cur_nx_s   = k_r;
                    state_nx_s = ST_RELEASE;
                end else begin
                    cnt_nx_s = cnt_inc_s;
                end
            end
            ST_RELEASE: begin
                req_n_nx_s[cur_r] = 1'b1;
                if (i_rst_ack_n[cur_r] || tmo_hit_s) begin
                    cnt_nx_s  = '0;
                    tmo_evt_s = !i_rst_ack_n[cur_r];
                    if (cur_r == LAST_STAGE) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        cur_nx_s = cur_r + 2'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_inc_s;
                end
            end
            ST_DONE: begin
                clr_mask_s = scope_mask(k_r);
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
                req_n_nx_s = '1;
                cnt_nx_s   = '0;
            end
        endcase

        // A fresh timeout takes priority over a software clear in the same cycle.
        if (tmo_evt_s) begin
            err_nx_s = 1'b1;
            if (!err_r) begin
                err_stage_nx_s = cur_r;
            end else begin
                err_stage_nx_s = err_stage_r;
            end
        end else if (i_err_clr) begin
            err_nx_s       = 1'b0;
            err_stage_nx_s = 2'd0;
        end else begin
            err_nx_s       = err_r;
            err_stage_nx_s = err_stage_r;
        end
    end

    // State, counters and registered outputs; a request bit in the clearing cycle stays pending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_IDLE;
            k_r         <= 2'd0;
            cur_r       <= 2'd0;
            cnt_r       <= '0;
            pending_r   <= '0;
            req_n_r     <= '1;
            err_r       <= 1'b0;
            err_stage_r <= 2'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            active_r    <= 2'd0;
        end else begin
            state_r     <= state_nx_s;
            k_r         <= k_nx_s;
            cur_r       <= cur_nx_s;
            cnt_r       <= cnt_nx_s;
            pending_r   <= (pending_r & ~clr_mask_s) | i_req;
            req_n_r     <= req_n_nx_s;
            err_r       <= err_nx_s;
            err_stage_r <= err_stage_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            done_r      <= (state_nx_s == ST_DONE);
            if (state_nx_s != ST_IDLE) begin
                active_r <= k_nx_s;
            end else begin
                active_r <= active_r;
            end
        end
    end

    assign o_rst_req_n    = req_n_r;
    assign o_busy         = busy_r;
    assign o_active_stage = active_r;
    assign o_done         = done_r;
    assign o_err          = err_r;
    assign o_err_stage    = err_stage_r;
    assign o_pending      = pending_r;

endmodule

// File: tb/tb_soc_mgmt_rst_seq_ctrl.sv
// Bench for soc_mgmt_rst_seq_ctrl: an ack model with a 3-cycle response plus an event
// scoreboard of expected req_n edges and done pulses, with cycle-accurate latency checks.
module tb_soc_mgmt_rst_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  ack_n;
    logic [15:0] hold_cyc;
    logic [15:0] tmo_cyc;
    logic        err_clr;
    logic [2:0]  req_n;
    logic        busy;
    logic [1:0]  active;
    logic        done;
    logic        err;
    logic [1:0]  err_stage;
    logic [2:0]  pending;

    soc_mgmt_rst_seq_ctrl #(.NUM_STAGES(3), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_rst_ack_n(ack_n),
        .i_hold_cycles(hold_cyc), .i_timeout_cycles(tmo_cyc), .i_err_clr(err_clr),
        .o_rst_req_n(req_n), .o_busy(busy), .o_active_stage(active), .o_done(done),
        .o_err(err), .o_err_stage(err_stage), .o_pending(pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: ack_n follows req_n three edges later; ack_block pins a stage's ack high.
    logic [2:0] p0 = 3'b111, p1 = 3'b111, p2 = 3'b111;
    logic [2:0] ack_block = 3'b000;
    always @(posedge clk) begin
        p0 <= req_n;
        p1 <= p0;
        p2 <= p1;
    end
    assign ack_n = p2 | ack_block;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    logic [7:0] exp_q[$];
    logic       sb_en = 1'b0;

    task automatic sb_pop(input logic [7:0] code);
        if (exp_q.size() == 0) begin
            chk_eq("sb_unexpected_evt", 32'(code), 32'hEE);
        end else begin
            chk_eq("sb_evt", 32'(code), 32'(exp_q.pop_front()));
        end
    endtask

    // Events: 0x1s = req_n[s] falls, 0x2s = req_n[s] rises, 0x30 = done pulse.
    task automatic push_seq(input int k);
        for (int s = 2; s >= k; s--) exp_q.push_back(8'h10 + 8'(s));
        for (int s = k; s <= 2; s++) exp_q.push_back(8'h20 + 8'(s));
        exp_q.push_back(8'h30);
    endtask

    int fall_cyc[3], rise_cyc[3], ack_f_cyc[3];
    int err_cyc = 0;
    int n_done  = 0;
    logic [2:0] prev_req_n = 3'b111, prev_ack_n = 3'b111;
    logic       prev_err   = 1'b0;

    // Output monitor on the falling edge: timestamps and scoreboard pops.
    always @(negedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (req_n[s] !== prev_req_n[s] && !$isunknown(req_n[s])) begin
                if (req_n[s]) rise_cyc[s] = cyc;
                else          fall_cyc[s] = cyc;
                if (sb_en) sb_pop(req_n[s] ? (8'h20 + 8'(s)) : (8'h10 + 8'(s)));
            end
            if (prev_ack_n[s] === 1'b1 && ack_n[s] === 1'b0) ack_f_cyc[s] = cyc;
        end
        if (done === 1'b1) begin
            n_done++;
            if (sb_en) sb_pop(8'h30);
        end
        if (prev_err === 1'b0 && err === 1'b1) err_cyc = cyc;
        prev_req_n = req_n;
        prev_ack_n = ack_n;
        prev_err   = err;
    end

    int req_edge = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic send_req(input logic [2:0] v);
        req = v;
        tick();
        req_edge = cyc;
        req = 3'b000;
    endtask

    task automatic wait_done(input int budget, input logic [1:0] exp_act, input string tag,
                             output int bad_act);
        int start;
        logic seen;
        start   = n_done;
        seen    = 1'b0;
        bad_act = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (busy && active !== exp_act) bad_act++;
            if (n_done != start) begin
                seen = 1'b1;
                break;
            end
        end
        chk_eq(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, d0;
        logic ok;
        rst = 1'b1; req = 3'b000; hold_cyc = 16'd4; tmo_cyc = 16'd50; err_clr = 1'b0;
        repeat (3) tick();
        chk_eq("rst_req_n", 32'(req_n), 32'h7);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_done", 32'(done), 32'd0);
        chk_eq("rst_err", 32'(err), 32'd0);
        chk_eq("rst_err_stage", 32'(err_stage), 32'd0);
        chk_eq("rst_active", 32'(active), 32'd0);
        chk_eq("rst_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        sb_en = 1'b1;

        // Single global-stage request.
        d0 = n_done;
        push_seq(2);
        send_req(3'b100);
        wait_done(100, 2'd2, "t1_done", bad);
        chk_eq("t1_latency", 32'(fall_cyc[2] - req_edge), 32'd2);
        chk_eq("t1_hold4", 32'(rise_cyc[2] - ack_f_cyc[2]), 32'd6);
        chk_eq("t1_active", 32'(bad), 32'd0);
        tick();
        chk_eq("t1_pending", 32'(pending), 32'd0);
        chk_eq("t1_err", 32'(err), 32'd0);
        chk_eq("t1_busy", 32'(busy), 32'd0);
        repeat (5) tick();
        chk_eq("t1_done_once", 32'(n_done - d0), 32'd1);

        // Full AO request.
        push_seq(0);
        send_req(3'b001);
        wait_done(200, 2'd0, "t2_done", bad);
        chk_eq("t2_active0", 32'(bad), 32'd0);
        chk_eq("t2_step21", 32'(fall_cyc[1] - ack_f_cyc[2]), 32'd2);
        chk_eq("t2_step10", 32'(fall_cyc[0] - ack_f_cyc[1]), 32'd2);
        tick();

        // Stage-1 ack never arrives: timeout of 10 cycles.
        tmo_cyc = 16'd10;
        ack_block = 3'b010;
        push_seq(1);
        send_req(3'b010);
        wait_done(200, 2'd1, "t3_done", bad);
        chk_eq("t3_err", 32'(err), 32'd1);
        chk_eq("t3_err_stage", 32'(err_stage), 32'd1);
        // req_n[1] falls one cycle into its 10-cycle step; err sets at the step exit.
        chk_eq("t3_tmo_len", 32'(err_cyc - fall_cyc[1]), 32'd9);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk_eq("t3_err_clr", 32'(err), 32'd0);
        chk_eq("t3_err_stage_clr", 32'(err_stage), 32'd0);
        ack_block = 3'b000;
        tmo_cyc = 16'd50;
        repeat (4) tick();

        // Queued AO request arriving during the global-stage hold.
        push_seq(2);
        send_req(3'b100);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack_n[2] === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq("t4_ack_wait", 32'(ok), 32'd1);
        tick();
        push_seq(0);
        send_req(3'b001);
        chk_eq("t4_pending_both", 32'(pending), 32'h5);
        wait_done(100, 2'd2, "t4_done1", bad);
        chk_eq("t4_active2", 32'(bad), 32'd0);
        tick();
        chk_eq("t4_pending_q", 32'(pending), 32'h1);
        wait_done(200, 2'd0, "t4_done2", bad);
        chk_eq("t4_active0", 32'(bad), 32'd0);
        chk_eq("t4_pending_at_done", 32'(pending), 32'h1);
        tick();
        chk_eq("t4_pending_clr", 32'(pending), 32'd0);
        repeat (3) tick();

        // Zero hold gives a single hold cycle.
        hold_cyc = 16'd0;
        push_seq(2);
        send_req(3'b100);
        wait_done(100, 2'd2, "t5_done", bad);
        chk_eq("t5_hold1", 32'(rise_cyc[2] - ack_f_cyc[2]), 32'd3);
        hold_cyc = 16'd4;
        repeat (3) tick();

        // Timeout disabled, ack withheld for 1000 cycles.
        tmo_cyc = 16'd0;
        ack_block = 3'b100;
        push_seq(2);
        send_req(3'b100);
        repeat (1000) tick();
        chk_eq("t6_no_err", 32'(err), 32'd0);
        chk_eq("t6_busy", 32'(busy), 32'd1);
        chk_eq("t6_req_n", 32'(req_n), 32'h3);
        ack_block = 3'b000;
        wait_done(100, 2'd2, "t6_done", bad);
        chk_eq("t6_err_end", 32'(err), 32'd0);
        tmo_cyc = 16'd50;
        repeat (3) tick();

        // Synchronous reset mid-sequence.
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h11);
        send_req(3'b001);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (req_n === 3'b001) begin
                ok = 1'b1;
                break;
            end
        end
        chk_eq("t7_reach", 32'(ok), 32'd1);
        sb_en = 1'b0;
        rst = 1'b1;
        tick();
        chk_eq("t7_req_n", 32'(req_n), 32'h7);
        chk_eq("t7_busy", 32'(busy), 32'd0);
        chk_eq("t7_pending", 32'(pending), 32'd0);
        rst = 1'b0;
        repeat (6) tick();

        chk_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
